// File: rtl/ctrl_carga_serie.sv
// ctrl_carga_serie: loads a parallel word and feeds it LSB-first into an
// external serial-in/serial-out shift chain at a programmable shift rate.
// Also clears the chain on request. Moore outputs; sr_reset additionally
// follows the reset input so the chain clears together with this block.
module ctrl_carga_serie #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] dato,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             sr_entrada,
    output logic             sr_enable,
    output logic             sr_reset
);

    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam int unsigned DW = $clog2(DIV + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;

    // Shift strobe point and last-bit detection, both from registered state only.
    logic div_wrap;
    logic last_bit;

    assign div_wrap = (div_cnt_q == DW'(DIV - 1));
    assign last_bit = (bit_cnt_q == BW'(WIDTH - 1));

    // State and datapath registers; synchronous reset returns to IDLE and drops any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    // Next-state, datapath update and Moore outputs.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        sr_enable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                // clear has priority; a simultaneous start is dropped
                if (clear) begin
                    state_d = ST_CLEAR;
                end else if (start) begin
                    state_d   = ST_SHIFT;
                    hold_d    = dato;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end
            end

            ST_CLEAR: begin
                busy    = 1'b1;
                state_d = ST_DONE;
            end

            ST_SHIFT: begin
                busy = 1'b1;
                if (div_wrap) begin
                    // chain samples hold[0] on this edge
                    sr_enable = 1'b1;
                    div_cnt_d = '0;
                    hold_d    = hold_q >> 1;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (last_bit) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end

            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Chain-facing signals: serial bit is the LSB of the holding register.
    assign sr_entrada = hold_q[0];
    assign sr_reset   = reset | (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ctrl_carga_serie.sv
// Bench for ctrl_carga_serie: two instances (DIV=1 and DIV=3), each driving
// its own 4-bit SISO chain model, checked every cycle against a timeline model.
module tb_ctrl_carga_serie;

    logic            clk;
    logic [1:0]      rst_i;
    logic [1:0]      st_i;
    logic [1:0]      clr_i;
    logic [1:0][3:0] dat_i;
    logic [1:0]      rdy_o;
    logic [1:0]      bsy_o;
    logic [1:0]      dn_o;
    logic [1:0]      ent_o;
    logic [1:0]      en_o;
    logic [1:0]      srr_o;
    logic [1:0][3:0] chain;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_carga_serie #(.WIDTH(4), .DIV(1)) u_dut0 (
        .clk(clk), .reset(rst_i[0]), .start(st_i[0]), .clear(clr_i[0]), .dato(dat_i[0]),
        .ready(rdy_o[0]), .busy(bsy_o[0]), .done(dn_o[0]),
        .sr_entrada(ent_o[0]), .sr_enable(en_o[0]), .sr_reset(srr_o[0])
    );

    ctrl_carga_serie #(.WIDTH(4), .DIV(3)) u_dut1 (
        .clk(clk), .reset(rst_i[1]), .start(st_i[1]), .clear(clr_i[1]), .dato(dat_i[1]),
        .ready(rdy_o[1]), .busy(bsy_o[1]), .done(dn_o[1]),
        .sr_entrada(ent_o[1]), .sr_enable(en_o[1]), .sr_reset(srr_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit SISO chains: sync reset, sync enable, new bit enters at Q[3]
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (srr_o[i])     chain[i] <= 4'b0000;
            else if (en_o[i]) chain[i] <= {ent_o[i], chain[i][3:1]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int dv(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Timeline model: op 0 = idle, 1 = clear, 2 = shift; m_c = cycle number since acceptance
    int         m_op [2];
    int         m_c  [2];
    logic [3:0] m_word  [2];
    logic [3:0] m_chain [2];
    bit         m_valid [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic int d = dv(i);
            if (rst_i[i]) begin
                m_valid[i] = 1'b1;
                m_op[i]    = 0;
                m_c[i]     = 0;
                m_chain[i] = 4'b0000;
            end else if (m_op[i] == 0) begin
                if (clr_i[i]) begin
                    m_op[i] = 1;
                    m_c[i]  = 1;
                end else if (st_i[i]) begin
                    m_op[i]   = 2;
                    m_c[i]    = 1;
                    m_word[i] = dat_i[i];
                end
            end else begin
                if (m_op[i] == 1 && m_c[i] == 1) m_chain[i] = 4'b0000;
                if (m_op[i] == 2 && m_c[i] <= 4 * d && (m_c[i] % d) == 0)
                    m_chain[i] = {m_word[i][2'((m_c[i] - 1) / d)], m_chain[i][3:1]};
                m_c[i]++;
                if ((m_op[i] == 1 && m_c[i] > 2) || (m_op[i] == 2 && m_c[i] > 4 * d + 1)) begin
                    m_op[i] = 0;
                    m_c[i]  = 0;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_valid[i]) begin
                automatic int   d      = dv(i);
                automatic logic shift  = (m_op[i] == 2) && (m_c[i] <= 4 * d);
                automatic logic done_e = (m_op[i] == 1 && m_c[i] == 2) ||
                                         (m_op[i] == 2 && m_c[i] == 4 * d + 1);
                automatic logic en_e   = shift && ((m_c[i] % d) == 0);
                automatic logic ent_e  = shift ? m_word[i][2'((m_c[i] - 1) / d)] : 1'b0;
                automatic logic srr_e  = rst_i[i] | (m_op[i] == 1 && m_c[i] == 1);
                chk($sformatf("i%0d ready", i),      32'(rdy_o[i]), 32'(m_op[i] == 0));
                chk($sformatf("i%0d busy", i),       32'(bsy_o[i]), 32'(m_op[i] != 0));
                chk($sformatf("i%0d done", i),       32'(dn_o[i]),  32'(done_e));
                chk($sformatf("i%0d sr_enable", i),  32'(en_o[i]),  32'(en_e));
                chk($sformatf("i%0d sr_entrada", i), 32'(ent_o[i]), 32'(ent_e));
                chk($sformatf("i%0d sr_reset", i),   32'(srr_o[i]), 32'(srr_e));
                chk($sformatf("i%0d chain", i),      32'(chain[i]), 32'(m_chain[i]));
            end
        end
    end

    logic [6:1]  t1_en, t1_ent, t1_dn, t1_rd;
    logic [14:1] t2_en, t2_dn;
    logic [12:1] t6_dn, t6_rd;
    int          dn_cnt;

    initial begin
        rst_i = 2'b11;
        st_i  = 2'b00;
        clr_i = 2'b00;
        dat_i = '0;
        tick();
        // reset state, reset still high
        @(negedge clk);
        chk("rst ready", 32'(rdy_o[0]), 32'd1);
        chk("rst busy", 32'(bsy_o[0]), 32'd0);
        chk("rst done", 32'(dn_o[0]), 32'd0);
        chk("rst sr_enable", 32'(en_o[0]), 32'd0);
        chk("rst sr_entrada", 32'(ent_o[0]), 32'd0);
        chk("rst sr_reset", 32'(srr_o[0]), 32'd1);
        tick();
        rst_i = 2'b00;
        tick();

        // 1: DIV=1, dato=1011
        st_i[0] = 1'b1; dat_i[0] = 4'b1011;
        tick();
        st_i[0] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            t1_en[c] = en_o[0]; t1_ent[c] = ent_o[0]; t1_dn[c] = dn_o[0]; t1_rd[c] = rdy_o[0];
            tick();
        end
        chk("t1 enable cycles", 32'(t1_en), 32'(6'b001111));
        chk("t1 entrada bits", 32'(t1_ent), 32'(6'b001011));
        chk("t1 done cycle", 32'(t1_dn), 32'(6'b010000));
        chk("t1 ready cycle", 32'(t1_rd), 32'(6'b100000));
        @(negedge clk);
        chk("t1 chain", 32'(chain[0]), 32'(4'b1011));
        tick();

        // 2: DIV=3, dato=0110
        st_i[1] = 1'b1; dat_i[1] = 4'b0110;
        tick();
        st_i[1] = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            t2_en[c] = en_o[1]; t2_dn[c] = dn_o[1];
            tick();
        end
        chk("t2 enable cycles", 32'(t2_en), 32'(14'b00100100100100));
        chk("t2 done cycle", 32'(t2_dn), 32'(14'b01000000000000));
        @(negedge clk);
        chk("t2 chain", 32'(chain[1]), 32'(4'b0110));
        tick();

        // 3: start while busy is ignored
        st_i[0] = 1'b1; dat_i[0] = 4'b0011;
        tick();
        st_i[0] = 1'b0;
        tick();
        st_i[0] = 1'b1; dat_i[0] = 4'b1111;
        tick();
        st_i[0] = 1'b0;
        dn_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dn_o[0] === 1'b1) dn_cnt++;
            tick();
        end
        chk("t3 done pulses", 32'(dn_cnt), 32'd1);
        @(negedge clk);
        chk("t3 chain", 32'(chain[0]), 32'(4'b0011));
        tick();

        // 4: load 1011, then clear and start together
        st_i[0] = 1'b1; dat_i[0] = 4'b1011;
        tick();
        st_i[0] = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("t4 chain loaded", 32'(chain[0]), 32'(4'b1011));
        tick();
        clr_i[0] = 1'b1; st_i[0] = 1'b1; dat_i[0] = 4'b1111;
        tick();
        clr_i[0] = 1'b0; st_i[0] = 1'b0;
        @(negedge clk);
        chk("t4 sr_reset", 32'(srr_o[0]), 32'd1);
        chk("t4 no shift", 32'(en_o[0]), 32'd0);
        tick();
        @(negedge clk);
        chk("t4 done", 32'(dn_o[0]), 32'd1);
        chk("t4 sr_reset off", 32'(srr_o[0]), 32'd0);
        tick();
        @(negedge clk);
        chk("t4 ready", 32'(rdy_o[0]), 32'd1);
        chk("t4 chain cleared", 32'(chain[0]), 32'(4'b0000));
        tick();

        // 5: reset after the 2nd enable discards the word
        st_i[0] = 1'b1; dat_i[0] = 4'b1001;
        tick();
        st_i[0] = 1'b0;
        tick();
        tick();
        rst_i[0] = 1'b1;
        @(negedge clk);
        chk("t5 chain partial", 32'(chain[0]), 32'(4'b0100));
        chk("t5 sr_reset", 32'(srr_o[0]), 32'd1);
        tick();
        rst_i[0] = 1'b0;
        @(negedge clk);
        chk("t5 ready", 32'(rdy_o[0]), 32'd1);
        chk("t5 chain", 32'(chain[0]), 32'(4'b0000));
        dn_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (dn_o[0] !== 1'b0) dn_cnt++;
            tick();
            @(negedge clk);
        end
        chk("t5 no done", 32'(dn_cnt), 32'd0);
        tick();

        // 6: start held high, two words back to back
        st_i[0] = 1'b1; dat_i[0] = 4'b1010;
        tick();
        dat_i[0] = 4'b0101;
        for (int c = 1; c <= 12; c++) begin
            if (c == 7) st_i[0] = 1'b0;
            @(negedge clk);
            t6_dn[c] = dn_o[0]; t6_rd[c] = rdy_o[0];
            tick();
        end
        chk("t6 done cycles", 32'(t6_dn), 32'(12'b010000010000));
        chk("t6 ready cycles", 32'(t6_rd), 32'(12'b100000100000));
        @(negedge clk);
        chk("t6 chain", 32'(chain[0]), 32'(4'b0101));
        tick();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
